// File: rtl/mcoc_boot_pkg.sv
// Shared definitions for the boot ROM loader: FSM encoding, ROM capacity default,
// halfword write masks and the RAM write payload record.
package mcoc_boot_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SIZE  = 3'd1;
   localparam logic [2:0] ST_FETCH = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam int ROM_HW_MAX_DEF = 256;

   localparam logic [1:0] WMSK_FULL = 2'b11;
   localparam logic [1:0] WMSK_LO   = 2'b01;

   typedef struct packed {
      logic [31:0] wdat;
      logic [1:0]  wmsk;
   } ram_wr_t;

   function automatic logic [15:0] clamp_siz(input logic [15:0] siz, input logic [15:0] max_hw);
      return (siz > max_hw) ? max_hw : siz;
   endfunction

endpackage

// File: rtl/boot_ram_wr_if.sv
// RAM write port holding register: captures one word, keeps req/adr/wdat/wmsk
// stable until the RAM acknowledges, then advances the destination address.
module boot_ram_wr_if
   import mcoc_boot_pkg::*;
#(
   parameter logic [15:0] DST_BASE = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init_i,
   input  logic        load_i,
   input  ram_wr_t     wr_i,
   input  logic        ack_i,
   output logic        req_o,
   output logic [15:0] adr_o,
   output logic [31:0] wdat_o,
   output logic [1:0]  wmsk_o,
   output logic        accept_o
);

   logic        req_q,  req_d;
   logic [15:0] adr_q,  adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [1:0]  wmsk_q, wmsk_d;

   // an ack without an outstanding request never counts
   assign accept_o = req_q & ack_i;

   always_comb begin
      req_d  = req_q;
      adr_d  = adr_q;
      wdat_d = wdat_q;
      wmsk_d = wmsk_q;
      if (init_i) begin
         adr_d = DST_BASE;
      end
      if (load_i) begin
         req_d  = 1'b1;
         wdat_d = wr_i.wdat;
         wmsk_d = wr_i.wmsk;
      end
      if (accept_o) begin
         req_d = 1'b0;
         adr_d = adr_q + 16'd2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q  <= 1'b0;
         adr_q  <= DST_BASE;
         wdat_q <= '0;
         wmsk_q <= '0;
      end else begin
         req_q  <= req_d;
         adr_q  <= adr_d;
         wdat_q <= wdat_d;
         wmsk_q <= wmsk_d;
      end
   end

   assign req_o  = req_q;
   assign adr_o  = adr_q;
   assign wdat_o = wdat_q;
   assign wmsk_o = wmsk_q;

endmodule

// File: rtl/boot_rom_loader.sv
// Copies the boot ROM image into program RAM after reset (or on ld_start_i),
// then releases the CPU core from reset.
module boot_rom_loader
   import mcoc_boot_pkg::*;
#(
   parameter logic [15:0] DST_BASE   = 16'h0000,
   parameter bit          AUTO_START = 1'b1,
   parameter int          ROM_HW_MAX = ROM_HW_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_start_i,
   output logic        rom_fcmdl_o,
   output logic [7:0]  rom_adr_o,
   input  logic [31:0] rom_dat_i,
   input  logic [15:0] rom_siz_i,
   output logic        ram_req_o,
   output logic [15:0] ram_adr_o,
   output logic [31:0] ram_wdat_o,
   output logic [1:0]  ram_wmsk_o,
   input  logic        ram_ack_i,
   output logic        ld_busy_o,
   output logic        ld_done_o,
   output logic        cpu_rst_n_o
);

   localparam logic [2:0]  ST_RST = AUTO_START ? ST_SIZE : ST_IDLE;
   localparam logic [15:0] HW_MAX = 16'(ROM_HW_MAX);

   logic [2:0]  state_q,   state_d;
   logic [15:0] cnt_q,     cnt_d;
   logic [7:0]  rom_adr_q, rom_adr_d;
   logic        busy_q,    busy_d;
   logic        done_q,    done_d;
   logic        cpu_rst_n_q, cpu_rst_n_d;

   logic        full;
   logic [15:0] step;
   logic [15:0] cnt_left;
   logic [15:0] siz_clamped;
   logic        wr_init;
   logic        wr_load;
   logic        wr_accept;
   ram_wr_t     wr_word;

   assign full        = (cnt_q >= 16'd2);
   assign step        = full ? 16'd2 : cnt_q;
   assign cnt_left    = cnt_q - step;
   assign siz_clamped = clamp_siz(rom_siz_i, HW_MAX);

   // odd tail: 16-bit ROM read, only the low halfword is written
   assign wr_word.wdat = full ? rom_dat_i : {16'h0000, rom_dat_i[15:0]};
   assign wr_word.wmsk = full ? WMSK_FULL : WMSK_LO;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rom_adr_d   = rom_adr_q;
      busy_d      = busy_q;
      done_d      = done_q;
      cpu_rst_n_d = cpu_rst_n_q;
      wr_init     = 1'b0;
      wr_load     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ld_start_i) state_d = ST_SIZE;
         end
         ST_SIZE: begin
            cnt_d       = siz_clamped;
            rom_adr_d   = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            cpu_rst_n_d = 1'b0;
            wr_init     = 1'b1;
            state_d     = (siz_clamped == 16'd0) ? ST_DONE : ST_FETCH;
         end
         ST_FETCH: begin
            wr_load = 1'b1;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (wr_accept) begin
               cnt_d = cnt_left;
               // the final word leaves rom_adr in place so it never steps past the ROM end
               if (cnt_left == 16'd0) begin
                  state_d = ST_DONE;
               end else begin
                  rom_adr_d = rom_adr_q + 8'd2;
                  state_d   = ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            busy_d      = 1'b0;
            done_d      = 1'b1;
            cpu_rst_n_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RST;
         cnt_q       <= '0;
         rom_adr_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cpu_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rom_adr_q   <= rom_adr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cpu_rst_n_q <= cpu_rst_n_d;
      end
   end

   boot_ram_wr_if #(
      .DST_BASE (DST_BASE)
   ) u_wr (
      .clk      (clk),
      .rst_n    (rst_n),
      .init_i   (wr_init),
      .load_i   (wr_load),
      .wr_i     (wr_word),
      .ack_i    (ram_ack_i),
      .req_o    (ram_req_o),
      .adr_o    (ram_adr_o),
      .wdat_o   (ram_wdat_o),
      .wmsk_o   (ram_wmsk_o),
      .accept_o (wr_accept)
   );

   assign rom_fcmdl_o = full;
   assign rom_adr_o   = rom_adr_q;
   assign ld_busy_o   = busy_q;
   assign ld_done_o   = done_q;
   assign cpu_rst_n_o = cpu_rst_n_q;

endmodule

// File: tb/tb_boot_rom_loader.sv
// Directed bench for boot_rom_loader: ROM model, acking RAM responder and a
// scoreboard deriving each expected RAM write from the image size alone.
module tb_boot_rom_loader;

   localparam logic [15:0] DST = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ld_start = 1'b0;
   logic        rom_fcmdl;
   logic [7:0]  rom_adr;
   logic [31:0] rom_dat;
   logic [15:0] rom_siz = 16'd0;
   logic        ram_req;
   logic [15:0] ram_adr;
   logic [31:0] ram_wdat;
   logic [1:0]  ram_wmsk;
   logic        ram_ack = 1'b0;
   logic        ld_busy;
   logic        ld_done;
   logic        cpu_rst_n;

   int n_chk = 0;
   int n_fail = 0;

   int exp_n = 0;
   int w0 = 0;
   int nlog = 0;
   int rq0 = 0;
   int req_cyc = 0;
   int wt = 0;
   int ack_dly = 0;
   int rom_adr_max = 0;
   logic spur = 1'b0;

   logic [15:0] log_adr[$];
   logic [31:0] log_dat[$];
   logic [1:0]  log_msk[$];
   logic        log_fc[$];

   always #5 clk = ~clk;

   function automatic logic [15:0] hw(input logic [7:0] a);
      return {a ^ 8'h5A, a};
   endfunction

   assign rom_dat = rom_fcmdl ? {hw(rom_adr), hw(rom_adr + 8'd1)} : {16'h0000, hw(rom_adr)};

   boot_rom_loader #(
      .DST_BASE   (DST),
      .AUTO_START (1'b1),
      .ROM_HW_MAX (256)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld_start_i  (ld_start),
      .rom_fcmdl_o (rom_fcmdl),
      .rom_adr_o   (rom_adr),
      .rom_dat_i   (rom_dat),
      .rom_siz_i   (rom_siz),
      .ram_req_o   (ram_req),
      .ram_adr_o   (ram_adr),
      .ram_wdat_o  (ram_wdat),
      .ram_wmsk_o  (ram_wmsk),
      .ram_ack_i   (ram_ack),
      .ld_busy_o   (ld_busy),
      .ld_done_o   (ld_done),
      .cpu_rst_n_o (cpu_rst_n)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // word k of the current copy, from the clamped image size
   function automatic int nwords();
      return (exp_n + 1) / 2;
   endfunction

   function automatic logic [31:0] exp_wdat(input int k);
      logic [7:0] a;
      a = 8'(2 * k);
      if (exp_n - 2 * k >= 2) return {hw(a), hw(a + 8'd1)};
      return {16'h0000, hw(a)};
   endfunction

   function automatic logic [1:0] exp_wmsk(input int k);
      return (exp_n - 2 * k >= 2) ? 2'b11 : 2'b01;
   endfunction

   // RAM responder + per-cycle compare against the model
   always @(negedge clk) begin
      int k;
      if (!rst_n) begin
         ram_ack = 1'b0;
         wt = 0;
      end else begin
         if (ld_busy && int'(rom_adr) > rom_adr_max) rom_adr_max = int'(rom_adr);
         if (ram_req) begin
            k = nlog - w0;
            req_cyc++;
            if (k >= nwords()) begin
               chk("extra_write", 32'(k), 32'(nwords()));
            end else begin
               chk("ram_adr",   32'(ram_adr),   32'(DST + 16'(2 * k)));
               chk("ram_wdat",  ram_wdat,        exp_wdat(k));
               chk("ram_wmsk",  32'(ram_wmsk),  32'(exp_wmsk(k)));
               chk("rom_fcmdl", 32'(rom_fcmdl), 32'(exp_n - 2 * k >= 2));
               chk("rom_adr",   32'(rom_adr),   32'(2 * k));
               chk("busy_wr",   32'(ld_busy),   32'd1);
            end
            if (wt >= ack_dly) begin
               ram_ack = 1'b1;
               wt = 0;
               log_adr.push_back(ram_adr);
               log_dat.push_back(ram_wdat);
               log_msk.push_back(ram_wmsk);
               log_fc.push_back(rom_fcmdl);
               nlog++;
            end else begin
               ram_ack = 1'b0;
               wt++;
            end
         end else begin
            ram_ack = spur;
            wt = 0;
         end
      end
   end

   task automatic start(input int siz);
      @(negedge clk);
      rom_siz = 16'(siz);
      exp_n = (siz > 256) ? 256 : siz;
      w0 = nlog;
      rq0 = req_cyc;
      ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_done(input int max, input string nm);
      int i;
      i = 0;
      while (!(ld_done && !ld_busy) && i < max) begin
         @(negedge clk);
         i++;
      end
      chk(nm, 32'(ld_done && !ld_busy), 32'd1);
   endtask

   initial begin
      // reset values, AUTO_START copy of 4 halfwords
      rst_n = 1'b0;
      rom_siz = 16'd4;
      exp_n = 4;
      #12;
      chk("rst_req",   32'(ram_req),   32'd0);
      chk("rst_adr",   32'(ram_adr),   32'(DST));
      chk("rst_wdat",  ram_wdat,       32'd0);
      chk("rst_wmsk",  32'(ram_wmsk),  32'd0);
      chk("rst_fcmdl", 32'(rom_fcmdl), 32'd0);
      chk("rst_radr",  32'(rom_adr),   32'd0);
      chk("rst_busy",  32'(ld_busy),   32'd0);
      chk("rst_done",  32'(ld_done),   32'd0);
      chk("rst_cpu",   32'(cpu_rst_n), 32'd0);
      @(negedge clk);
      w0 = nlog;
      rq0 = req_cyc;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("cpu_t5", 32'(cpu_rst_n), 32'd0);
      @(posedge clk);
      #1 chk("cpu_t6", 32'(cpu_rst_n), 32'd1);
      chk("done_t6", 32'(ld_done), 32'd1);
      chk("busy_t6", 32'(ld_busy), 32'd0);
      chk("s4_nwr",  32'(nlog - w0), 32'd2);
      if (nlog - w0 >= 2) begin
         chk("s4_adr0", 32'(log_adr[w0]),     32'h0000);
         chk("s4_dat0", log_dat[w0],          32'h5A005B01);
         chk("s4_adr1", 32'(log_adr[w0 + 1]), 32'h0002);
         chk("s4_dat1", log_dat[w0 + 1],      32'h58025903);
         chk("s4_msk1", 32'(log_msk[w0 + 1]), 32'd3);
      end

      // odd size; rom_siz changed mid-copy must not matter
      start(5);
      rom_siz = 16'd100;
      wait_done(60, "s5_done");
      chk("s5_nwr", 32'(nlog - w0), 32'd3);
      if (nlog - w0 >= 3) begin
         chk("s5_adr2", 32'(log_adr[w0 + 2]), 32'h0004);
         chk("s5_dat2", log_dat[w0 + 2],      32'h00005E04);
         chk("s5_msk2", 32'(log_msk[w0 + 2]), 32'd1);
         chk("s5_fc2",  32'(log_fc[w0 + 2]),  32'd0);
      end
      chk("s5_cpu", 32'(cpu_rst_n), 32'd1);

      // empty image; ld_start during the DONE cycle is ignored
      @(negedge clk);
      rom_siz = 16'd0;
      exp_n = 0;
      w0 = nlog;
      rq0 = req_cyc;
      ld_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ld_start = 1'b0;
      @(posedge clk);
      #1 chk("s0_done1", 32'(ld_done),   32'd0);
      chk("s0_busy1", 32'(ld_busy),   32'd1);
      chk("s0_cpu1",  32'(cpu_rst_n), 32'd0);
      @(negedge clk);
      ld_start = 1'b1;
      @(posedge clk);
      #1 chk("s0_done2", 32'(ld_done),   32'd1);
      chk("s0_cpu2",  32'(cpu_rst_n), 32'd1);
      chk("s0_busy2", 32'(ld_busy),   32'd0);
      @(negedge clk);
      ld_start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("s0_done_hold", 32'(ld_done), 32'd1);
         chk("s0_idle",      32'(ld_busy), 32'd0);
      end
      chk("s0_noreq", 32'(req_cyc - rq0), 32'd0);

      // slow RAM (3-cycle wait) with stray acks outside requests
      ack_dly = 3;
      spur = 1'b1;
      start(6);
      wait_done(200, "dly_done");
      chk("dly_nwr",  32'(nlog - w0),     32'd3);
      chk("dly_rcyc", 32'(req_cyc - rq0), 32'd12);
      if (nlog - w0 >= 3) begin
         chk("dly_adr1", 32'(log_adr[w0 + 1]), 32'h0002);
         chk("dly_adr2", 32'(log_adr[w0 + 2]), 32'h0004);
      end
      ack_dly = 0;
      spur = 1'b0;

      // oversize image clamps to ROM capacity
      @(negedge clk);
      rom_adr_max = 0;
      start(300);
      wait_done(1000, "big_done");
      chk("big_nwr",  32'(nlog - w0),    32'd128);
      chk("big_last", 32'(log_adr[nlog - 1]), 32'(DST + 16'd254));
      chk("big_rmax", 32'(rom_adr_max), 32'd254);

      // reset mid-copy, then ld_start while busy
      start(8);
      for (int i = 0; i < 100 && (nlog - w0) < 2; i++) @(negedge clk);
      chk("mid_reach", 32'((nlog - w0) >= 2), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("mid_req", 32'(ram_req),   32'd0);
      chk("mid_busy",  32'(ld_busy),   32'd0);
      chk("mid_done",  32'(ld_done),   32'd0);
      chk("mid_cpu",   32'(cpu_rst_n), 32'd0);
      chk("mid_radr",  32'(rom_adr),   32'd0);
      chk("mid_adr",   32'(ram_adr),   32'(DST));
      chk("mid_wdat",  ram_wdat,       32'd0);
      @(negedge clk);
      w0 = nlog;
      rq0 = req_cyc;
      exp_n = 8;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("re_busy", 32'(ld_busy), 32'd1);
      ld_start = 1'b1;
      @(negedge clk);
      ld_start = 1'b0;
      wait_done(100, "re_done");
      repeat (10) @(negedge clk);
      chk("re_nwr",  32'(nlog - w0), 32'd4);
      chk("re_idle", 32'(ld_busy),   32'd0);
      if (nlog - w0 >= 1) chk("re_adr0", 32'(log_adr[w0]), 32'(DST));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
